// File: rtl/uart_stream_bridge.sv
// uart_stream_bridge: connects a DATA_W-bit ready/valid core stream either
// straight to a direct word port (bypass) or to a byte-serial UART pair.
// UART bytes are packed LSB-first into words; core words are unpacked
// LSB-first into TX FIFO writes, throttled by uart_tx_afull.
// Optional build macro RX_TIMEOUT_EN enables the inter-byte timeout that
// discards stale partial words and raises rx_timeout.
module uart_stream_bridge #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bypass_uart,
    output logic              mode_active,
    input  logic [DATA_W-1:0] direct_in_data,
    input  logic              direct_in_valid,
    output logic              direct_in_ready,
    output logic [DATA_W-1:0] direct_out_data,
    output logic              direct_out_valid,
    input  logic              direct_out_ready,
    input  logic [7:0]        uart_rx_byte,
    input  logic              uart_rx_valid,
    output logic [7:0]        uart_tx_byte,
    output logic              uart_tx_en,
    input  logic              uart_tx_afull,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    input  logic [DATA_W-1:0] core_out_data,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic              clear_flags,
    output logic              rx_overrun,
    output logic              rx_timeout
);
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    typedef enum logic {IDLE, SEND} tx_state_t;

    logic              mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] pack_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_valid_q;
    logic              overrun_q;
    tx_state_t         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  idx_q;

    logic              uart_mode;
    logic              quiescent;
    logic              rx_fire;
    logic              rx_last;
    logic              pop;
    logic              overrun_set;
    logic              tx_accept;
    logic              tx_send;
    logic              timeout_fire;
    logic [DATA_W-1:0] word_d;

    assign uart_mode   = ~mode_q;
    assign quiescent   = (cnt_q == '0) && !hold_valid_q && (state_q == IDLE);
    assign rx_fire     = uart_mode & uart_rx_valid;
    assign rx_last     = rx_fire & (cnt_q == LAST);
    assign pop         = uart_mode & hold_valid_q & core_in_ready;
    assign overrun_set = rx_last & hold_valid_q & ~pop;
    assign tx_accept   = uart_mode & (state_q == IDLE) & core_out_valid;
    assign tx_send     = (state_q == SEND) & ~uart_tx_afull;
    assign mode_active = mode_q;
    assign rx_overrun  = overrun_q;

    // Merge the incoming byte into its lane of the partial word.
    always_comb begin
        word_d = pack_q;
        for (int k = 0; k < BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) word_d[8*k +: 8] = uart_rx_byte;
        end
    end

    // Effective mode only follows the request when nothing is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mode_q <= 1'b0;
        else if (quiescent) mode_q <= bypass_uart;
    end

    // RX packer: byte counter and partial-word accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else if (timeout_fire) begin
            cnt_q <= '0;
        end else if (rx_fire) begin
            cnt_q  <= rx_last ? '0 : cnt_q + CNT_W'(1);
            pack_q <= word_d;
        end
    end

    // Holding register: a completed word is kept unless one is still waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (rx_last && (!hold_valid_q || pop)) begin
            hold_q       <= word_d;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    // Sticky overrun flag; a same-cycle set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else if (overrun_set) overrun_q <= 1'b1;
        else if (clear_flags) overrun_q <= 1'b0;
    end

    // TX unpacker FSM: latch one word, then shift out a byte per free cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_accept) begin
                        shift_q <= core_out_data;
                        idx_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (!uart_tx_afull) begin
                        shift_q <= shift_q >> 8;
                        idx_q   <= idx_q + CNT_W'(1);
                        if (idx_q == LAST) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    assign timeout_fire = uart_mode && (cnt_q != '0) && !rx_fire &&
                          (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign rx_timeout   = timeout_q;

    // Idle-cycle counter; only runs while a partial word is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else if ((cnt_q == '0) || rx_fire || timeout_fire) to_cnt_q <= '0;
        else to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    // Sticky timeout flag; a same-cycle set beats clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) timeout_q <= 1'b0;
        else if (timeout_fire) timeout_q <= 1'b1;
        else if (clear_flags) timeout_q <= 1'b0;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_fire       = 1'b0;
    assign rx_timeout         = 1'b0;
`endif

    // Output steering: pass-through in bypass, packer/unpacker/monitor in UART mode.
    always_comb begin
        core_in_data     = hold_q;
        core_in_valid    = hold_valid_q;
        direct_in_ready  = 1'b0;
        core_out_ready   = (state_q == IDLE);
        direct_out_data  = core_out_data;
        direct_out_valid = core_out_valid & (state_q == IDLE);
        uart_tx_en       = tx_send;
        uart_tx_byte     = shift_q[7:0];
        if (mode_q) begin
            core_in_data     = direct_in_data;
            core_in_valid    = direct_in_valid;
            direct_in_ready  = core_in_ready;
            core_out_ready   = direct_out_ready;
            direct_out_valid = core_out_valid;
            uart_tx_en       = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed testbench for uart_stream_bridge (DATA_W = 32).
module tb_uart_stream_bridge;
    localparam int DW = 32;
`ifdef RX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1000000;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          bypass_uart;
    logic          mode_active;
    logic [DW-1:0] direct_in_data;
    logic          direct_in_valid;
    logic          direct_in_ready;
    logic [DW-1:0] direct_out_data;
    logic          direct_out_valid;
    logic          direct_out_ready;
    logic [7:0]    uart_rx_byte;
    logic          uart_rx_valid;
    logic [7:0]    uart_tx_byte;
    logic          uart_tx_en;
    logic          uart_tx_afull;
    logic [DW-1:0] core_in_data;
    logic          core_in_valid;
    logic          core_in_ready;
    logic [DW-1:0] core_out_data;
    logic          core_out_valid;
    logic          core_out_ready;
    logic          clear_flags;
    logic          rx_overrun;
    logic          rx_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    uart_stream_bridge #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .bypass_uart(bypass_uart), .mode_active(mode_active),
        .direct_in_data(direct_in_data), .direct_in_valid(direct_in_valid),
        .direct_in_ready(direct_in_ready), .direct_out_data(direct_out_data),
        .direct_out_valid(direct_out_valid), .direct_out_ready(direct_out_ready),
        .uart_rx_byte(uart_rx_byte), .uart_rx_valid(uart_rx_valid),
        .uart_tx_byte(uart_tx_byte), .uart_tx_en(uart_tx_en), .uart_tx_afull(uart_tx_afull),
        .core_in_data(core_in_data), .core_in_valid(core_in_valid),
        .core_in_ready(core_in_ready), .core_out_data(core_out_data),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
        .clear_flags(clear_flags), .rx_overrun(rx_overrun), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_byte  = b;
        uart_rx_valid = 1'b1;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got_b[$];
        int         got_c[$];
        logic [7:0] exp_b[4];

        reset = 1'b1; bypass_uart = 1'b0;
        direct_in_data = '0; direct_in_valid = 1'b0; direct_out_ready = 1'b0;
        uart_rx_byte = '0; uart_rx_valid = 1'b0; uart_tx_afull = 1'b0;
        core_in_ready = 1'b0; core_out_data = '0; core_out_valid = 1'b0;
        clear_flags = 1'b0;
        tick(); tick();
        check("reset_mode", mode_active, 0);
        check("reset_core_in_valid", core_in_valid, 0);
        check("reset_tx_en", uart_tx_en, 0);
        check("reset_flags", {rx_overrun, rx_timeout}, 0);
        reset = 1'b0;
        tick();

        // 1: pack 4 bytes LSB first
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        check("t1_partial_no_valid", core_in_valid, 0);
        check("t1_direct_in_ready", direct_in_ready, 0);
        send_byte(8'h12);
        check("t1_valid", core_in_valid, 1);
        check("t1_word", core_in_data, 64'h12345678);
        core_in_ready = 1'b1;
        tick();
        check("t1_popped", core_in_valid, 0);
        core_in_ready = 1'b0;

        // 2: unpack a word, then the same word with afull mid-word
        exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        core_out_data = 32'hA1B2C3D4; core_out_valid = 1'b1;
        #1;
        check("t2_out_ready", core_out_ready, 1);
        check("t2_monitor_valid", direct_out_valid, 1);
        check("t2_monitor_data", direct_out_data, 64'hA1B2C3D4);
        tick();
        core_out_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_en_%0d", i), uart_tx_en, 1);
            check($sformatf("t2_byte_%0d", i), uart_tx_byte, exp_b[i]);
            check($sformatf("t2_busy_%0d", i), core_out_ready, 0);
            tick();
        end
        check("t2_done_en", uart_tx_en, 0);
        check("t2_ready_again", core_out_ready, 1);
        core_out_valid = 1'b1;
        tick();
        core_out_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            uart_tx_afull = (c >= 2 && c <= 4);
            #1;
            if (uart_tx_en) begin
                got_b.push_back(uart_tx_byte);
                got_c.push_back(c);
            end
            tick();
        end
        uart_tx_afull = 1'b0;
        check("t2_afull_count", got_b.size(), 4);
        if (got_b.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t2_afull_byte_%0d", i), got_b[i], exp_b[i]);
            check("t2_afull_gap", {got_c[0][7:0], got_c[1][7:0], got_c[2][7:0], got_c[3][7:0]},
                  64'h00010506);
        end

        // 3: overrun, clear, complete-and-pop, set-beats-clear
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("t3_overrun", rx_overrun, 1);
        check("t3_first_held", core_in_data, 64'h04030201);
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        check("t3_cleared", rx_overrun, 0);
        send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
        core_in_ready = 1'b1;
        send_byte(8'h34);
        check("t3_pop_same_cycle_valid", core_in_valid, 1);
        check("t3_pop_same_cycle_word", core_in_data, 64'h34333231);
        check("t3_no_overrun", rx_overrun, 0);
        core_in_ready = 1'b0;
        send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
        clear_flags = 1'b1;
        send_byte(8'h44);
        clear_flags = 1'b0;
        check("t3_set_beats_clear", rx_overrun, 1);
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        core_in_ready = 1'b1; tick(); core_in_ready = 1'b0;
        check("t3_drained", core_in_valid, 0);

        // 4: mode change waits for quiescence
        send_byte(8'h01); send_byte(8'h02);
        bypass_uart = 1'b1;
        tick(); tick();
        check("t4_pending_partial", mode_active, 0);
        send_byte(8'h03); send_byte(8'h04);
        check("t4_pending_hold", mode_active, 0);
        check("t4_word", core_in_data, 64'h04030201);
        core_in_ready = 1'b1;
        tick();
        check("t4_pop_cycle_mode", mode_active, 0);
        tick();
        check("t4_switched", mode_active, 1);
        direct_in_data = 32'hDEADBEEF; direct_in_valid = 1'b1;
        #1;
        check("t4_bypass_valid", core_in_valid, 1);
        check("t4_bypass_data", core_in_data, 64'hDEADBEEF);
        check("t4_bypass_ready", direct_in_ready, 1);
        direct_in_valid = 1'b0;
        core_out_data = 32'h0BADF00D; core_out_valid = 1'b1; direct_out_ready = 1'b0;
        #1;
        check("t4_out_ready_follows", core_out_ready, 0);
        check("t4_out_pass", {direct_out_valid, direct_out_data}, {1'b1, 32'h0BADF00D});
        core_out_valid = 1'b0;

        // 5: bytes ignored in bypass, pack count restarts at 0
        send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
        check("t5_no_core_in", core_in_valid, 0);
        check("t5_no_tx", uart_tx_en, 0);
        bypass_uart = 1'b0;
        tick();
        check("t5_back_uart", mode_active, 0);
        core_in_ready = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check("t5_word", {core_in_valid, core_in_data}, {1'b1, 32'h44332211});
        core_in_ready = 1'b1; tick(); core_in_ready = 1'b0;

        // 6: inter-byte timeout (or persistence without it)
        send_byte(8'hAA); send_byte(8'hBB);
`ifdef RX_TIMEOUT_EN
        repeat (15) tick();
        check("t6_before_timeout", rx_timeout, 0);
        tick();
        check("t6_timeout", rx_timeout, 1);
        send_byte(8'h11); send_byte(8'h12); send_byte(8'h13); send_byte(8'h14);
        check("t6_word", {core_in_valid, core_in_data}, {1'b1, 32'h14131211});
`else
        repeat (20) tick();
        check("t6_no_timeout", rx_timeout, 0);
        send_byte(8'hCC); send_byte(8'hDD);
        check("t6_persisted_word", {core_in_valid, core_in_data}, {1'b1, 32'hDDCCBBAA});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_stream_bridge.md
Name: uart_stream_bridge

Overview:
- Parametrised successor to the byte-wide simulation bypass wrapper.
- Bridges a DATA_W-bit ready/valid core stream to either a direct word port (bypass) or a byte-serial UART pair (UART mode).
- Packs incoming UART bytes into words and unpacks core words into bytes, LSB first, with backpressure from the TX FIFO.
- Sits between the UART RX/TX FIFO instances and the user core, in simulation tops and FPGA tops.

Parameters:
- DATA_W, 32, core word width in bits; must be a multiple of 8, range 8..64; BYTES = DATA_W/8.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; used only with RX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bypass_uart  in  1  requested mode: 1 = direct, 0 = UART
- mode_active  out  1  effective mode currently applied
- direct_in_data  in  DATA_W  direct input word
- direct_in_valid  in  1  direct input valid
- direct_in_ready  out  1  direct input ready
- direct_out_data  out  DATA_W  direct output / monitor word
- direct_out_valid  out  1  direct output valid
- direct_out_ready  in  1  direct output ready (bypass mode only)
- uart_rx_byte  in  8  byte from UART receiver
- uart_rx_valid  in  1  one-cycle byte strobe; cannot be backpressured
- uart_tx_byte  out  8  byte to UART TX FIFO
- uart_tx_en  out  1  one-cycle write strobe to TX FIFO
- uart_tx_afull  in  1  TX FIFO almost full
- core_in_data / core_in_valid  out  DATA_W / 1  word stream to core
- core_in_ready  in  1  core accepts word
- core_out_data / core_out_valid  in  DATA_W / 1  word stream from core
- core_out_ready  out  1  bridge accepts word
- clear_flags  in  1  clears sticky flags
- rx_overrun  out  1  sticky: completed word dropped
- rx_timeout  out  1  sticky: partial word discarded (0 without macro)

Behaviour:
Reset:
- All valids, uart_tx_en, flags and counters = 0.
- mode_active = 0.
- Holding register empty; unpacker in IDLE.

Mode change:
- bypass_uart is sampled each cycle. mode_active updates on the next edge only when the bridge is quiescent: pack count = 0, holding register empty, unpacker in IDLE.
- Otherwise the change stays pending until quiescent.

Bypass mode (mode_active = 1), combinational pass-through, zero latency:
- core_in_* = direct_in_*; direct_in_ready = core_in_ready.
- direct_out_* = core_out_*; core_out_ready = direct_out_ready.
- uart_rx_valid bytes are ignored and not counted; uart_tx_en = 0.

UART mode, RX packer:
- Byte counter 0..BYTES-1. Byte k lands in bits [8k+7:8k].
- On byte BYTES-1, the assembled word moves to the holding register and core_in_valid = 1 on the next cycle.
- Holding register clears on core_in_valid & core_in_ready.
- If a word completes while the holding register is still full (and not popped that cycle), the new word is dropped and rx_overrun is set. The counter still wraps to 0.
- Complete-and-pop in the same cycle: new word is held, no overrun.
- direct_in_ready = 0.

UART mode, TX unpacker, FSM IDLE -> SEND -> IDLE:
- IDLE: core_out_ready = 1; on handshake, latch the word, index = 0, go to SEND.
- SEND: core_out_ready = 0. Each cycle with uart_tx_afull = 0: uart_tx_en = 1, uart_tx_byte = byte[index], index++.
- After byte BYTES-1 is emitted, return to IDLE. Earliest next accept is the cycle after the last byte.
- While uart_tx_afull = 1, hold index with no strobe.
- Minimum BYTES+1 cycles per word.

Monitor:
- In UART mode, direct_out_data = core_out_data and direct_out_valid = core_out_valid & core_out_ready.
- direct_out_ready is ignored.

Flags:
- clear_flags clears sticky flags. If a set event occurs in the same cycle, set wins.

Reset mid-operation:
- Partial words and unsent bytes are discarded with no output strobe.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined: a counter runs while the pack count is nonzero and restarts on each byte. When it reaches TIMEOUT_CYCLES with no byte received, the partial word is discarded, the count goes to 0 and rx_timeout is set.
- Not defined: no counter, rx_timeout tied to 0, partial words persist indefinitely.

Test Plan:
1. DATA_W=32, UART mode, bytes 0x78,0x56,0x34,0x12 -> one core_in word 0x12345678; core_in_valid asserted the cycle after the 4th byte.
2. core_out word 0xA1B2C3D4 with afull=0 -> uart_tx_en on 4 consecutive cycles carrying D4,C3,B2,A1. Raise afull for 3 cycles mid-word -> the same byte order with a 3-cycle gap and no duplicate bytes.
3. core_in_ready=0; send 8 bytes 0x01..0x08 -> first word 0x04030201 held, second word dropped, rx_overrun=1; clear_flags -> rx_overrun=0.
4. Toggle bypass_uart to 1 after 2 of 4 bytes -> mode_active stays 0 until bytes 3 and 4 arrive and the word is popped, then becomes 1. A direct word 0xDEADBEEF then reaches core_in in the same cycle.
5. Bypass mode, uart_rx_valid pulses -> no core_in_valid; switch back to UART mode -> pack count starts at 0.
6. RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: 2 bytes, then 16 idle cycles -> rx_timeout=1. Then 4 bytes 0x11..0x14 -> word 0x14131211.
